axis_sync_fifo: RTL and testbench
=================================

AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, tdata width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, storage depth in beats; power of 2, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports s_tdata/s_tvalid/s_tlast  input  DW/1/1  upstream AXI-Stream beat (fed from the 2:1 stream mux m_* output).
REQ-006 SHALL have port s_tready  output  1  upstream ready.
REQ-007 SHALL have ports m_tdata/m_tvalid/m_tlast  output  DW/1/1  downstream AXI-Stream beat.
REQ-008 SHALL have port m_tready  input  1  downstream ready.
REQ-009 SHALL have ports full, empty  output  1 each  storage status.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  beats currently stored.

Function
REQ-011 SHALL store beats first-in first-out, with tdata and tlast kept together per entry.
REQ-012 SHALL accept a write when s_tvalid && s_tready; s_tready = !full && !rst.
REQ-013 SHALL perform a read when m_tvalid && m_tready; m_tvalid = !empty.
REQ-014 SHALL be first-word-fall-through: the head entry drives m_tdata/m_tlast combinationally from storage; m_tdata and m_tlast = 0 while empty.
REQ-015 SHALL have write-to-output latency of 1 cycle: a beat written at edge N is visible at m_* after edge N; no same-cycle pass-through when empty.
REQ-016 SHALL hold m_tdata/m_tlast stable while m_tvalid && !m_tready.
REQ-017 SHALL use write/read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0 without gaps.
REQ-018 SHALL update count +1 on a write only, -1 on a read only, and leave it unchanged on a simultaneous write and read.
REQ-019 SHALL assert full iff count == DEPTH and empty iff count == 0.
REQ-020 SHALL, when full with m_tready=1, perform the read and keep s_tready=0 in that cycle; s_tready rises the following cycle.
REQ-021 SHALL, when empty with s_tvalid=1, perform the write only; m_tvalid rises the following cycle.
REQ-022 SHALL never overflow or underflow under any input sequence; s_tvalid while full and m_tready while empty have no effect.
REQ-023 SHALL not inspect tlast for flow control; packets larger than DEPTH pass through unmodified.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear pointers and count to 0, giving empty=1, full=0, m_tvalid=0, m_tdata=0, m_tlast=0.
REQ-025 SHALL drive s_tready=0 combinationally while rst=1.
REQ-026 SHALL discard all stored beats on a reset mid-operation; storage contents are not cleared and are unobservable after reset.

Configuration
REQ-027 SHALL, with macro AXIS_SYNC_FIFO_PKT_CNT_EN defined, add port pkt_cnt  output  $clog2(DEPTH)+1  number of complete packets (stored tlast=1 beats).
REQ-028 SHALL, with the macro defined, increment pkt_cnt on a write with s_tlast=1, decrement it on a read with m_tlast=1, hold it when both occur, and reset it to 0.
REQ-029 SHALL, without the macro, omit pkt_cnt and its logic; all other behaviour is identical.

Verification (DW=8, DEPTH=4)
REQ-030 SHALL cover fill/drain: write 0x11,0x22,0x33,0x44 with m_tready=0 -> full=1, s_tready=0, count=4; then m_tready=1 -> 0x11..0x44 out in order, empty=1.
REQ-031 SHALL cover latency: single write 0xA5 at edge N into an empty FIFO -> m_tvalid=1, m_tdata=0xA5 after edge N, not before.
REQ-032 SHALL cover simultaneous traffic: s_tvalid=m_tready=1 continuously with count=2 -> count stays 2 and throughput is 1 beat/cycle.
REQ-033 SHALL cover wrap: 10 write/read beats 0x00..0x09 with a random m_tready pattern -> output order 0x00..0x09 with no loss or duplication.
REQ-034 SHALL cover reset mid-operation: count=3, assert rst for 1 cycle -> count=0, m_tvalid=0, m_tdata=0, s_tready=0 during rst and 1 after.
REQ-035 SHALL cover pkt_cnt with the macro defined: write a 3-beat packet then a 1-beat packet -> pkt_cnt=2; read 3 beats -> pkt_cnt=1.

Source files
------------

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO, first-word-fall-through, tdata+tlast stored per entry.
// Define AXIS_SYNC_FIFO_PKT_CNT_EN to add the pkt_cnt output (stored tlast=1 beats).
module axis_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic [DW-1:0]            m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
  ,
  output logic [$clog2(DEPTH):0]   pkt_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW:0]   head;
  logic          wr_en, rd_en;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign s_tready = !full && !rst;
  assign m_tvalid = !empty;
  assign wr_en    = s_tvalid && s_tready;
  assign rd_en    = m_tvalid && m_tready;

  // Head entry falls through combinationally; outputs are forced to zero when empty.
  assign head    = mem[rd_ptr];
  assign m_tdata = empty ? '0 : head[DW-1:0];
  assign m_tlast = !empty && head[DW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
  logic pkt_in, pkt_out;
  assign pkt_in  = wr_en && s_tlast;
  assign pkt_out = rd_en && m_tlast;

  always_ff @(posedge clk) begin
    if (rst) pkt_cnt <= '0;
    else begin
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo at DW=8, DEPTH=4; inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_axis_sync_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tready;
  logic       full, empty;
  logic [2:0] count;
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
  logic [2:0] pkt_cnt;
`endif

  int tests = 0;
  int fails = 0;

  axis_sync_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .full(full), .empty(empty), .count(count)
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
    #1;
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL rst_tready_during got %b exp 0", s_tready); end
    tick(); tick();
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL rst_flags got empty=%b full=%b exp 1/0", empty, full); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    tests++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
      fails++; $display("FAIL rst_mout got v=%b d=%h l=%b exp 0/00/0", m_tvalid, m_tdata, m_tlast); end
    rst = 1'b0;
    #1;
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_tready_after got %b exp 1", s_tready); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h11 * (i + 1)); s_tlast = (i == 3);
      tick();
    end
    s_tdata = 8'h55; s_tlast = 1'b0;
    tests++; if (full !== 1'b1 || s_tready !== 1'b0 || count !== 3'd4) begin
      fails++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d exp 1/0/4", full, s_tready, count); end
    tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_no_overflow got %0d exp 4", count); end
    // Full with m_tready=1: read happens, write is refused this cycle.
    s_tdata = 8'h66; m_tready = 1'b1;
    #1;
    tests++; if (s_tready !== 1'b0 || m_tdata !== 8'h11) begin
      fails++; $display("FAIL full_read_cycle got rdy=%b d=%h exp 0/11", s_tready, m_tdata); end
    tick();
    s_tvalid = 1'b0;
    tests++; if (count !== 3'd3 || s_tready !== 1'b1) begin
      fails++; $display("FAIL full_read_after got cnt=%0d rdy=%b exp 3/1", count, s_tready); end
    for (int i = 1; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      tests++; if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== (i == 3)) begin
        fails++; $display("FAIL drain_%0d got v=%b d=%h l=%b exp 1/%h/%b", i, m_tvalid, m_tdata, m_tlast, exp, (i == 3)); end
      tick();
    end
    tests++; if (empty !== 1'b1 || m_tvalid !== 1'b0 || m_tdata !== 8'h00 || count !== 3'd0) begin
      fails++; $display("FAIL drain_empty got e=%b v=%b d=%h cnt=%0d exp 1/0/00/0", empty, m_tvalid, m_tdata, count); end
    tick();
    tests++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL no_underflow got cnt=%0d exp 0", count); end
    m_tready = 1'b0;
  endtask

  task automatic test_latency();
    s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0;
    #1;
    tests++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00) begin
      fails++; $display("FAIL lat_no_passthru got v=%b d=%h exp 0/00", m_tvalid, m_tdata); end
    tick();
    s_tvalid = 1'b0;
    tests++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5 || count !== 3'd1) begin
      fails++; $display("FAIL lat_visible got v=%b d=%h cnt=%0d exp 1/a5/1", m_tvalid, m_tdata, count); end
    tick(); tick();
    tests++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin
      fails++; $display("FAIL lat_stall_hold got v=%b d=%h exp 1/a5", m_tvalid, m_tdata); end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL lat_read got empty=%b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    m_tready = 1'b0; s_tvalid = 1'b1; s_tlast = 1'b0;
    s_tdata = 8'h01; tick();
    s_tdata = 8'h02; tick();
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tdata = 8'(3 + i);
      exp = 8'(1 + i);
      #1;
      tests++; if (m_tdata !== exp || s_tready !== 1'b1) begin
        fails++; $display("FAIL b2b_out_%0d got d=%h rdy=%b exp %h/1", i, m_tdata, s_tready, exp); end
      tick();
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count_%0d got %0d exp 2", i, count); end
    end
    s_tvalid = 1'b0;
    tests++; if (m_tdata !== 8'h07) begin fails++; $display("FAIL b2b_tail0 got %h exp 07", m_tdata); end
    tick();
    tests++; if (m_tdata !== 8'h08) begin fails++; $display("FAIL b2b_tail1 got %h exp 08", m_tdata); end
    tick();
    m_tready = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %b exp 1", empty); end
  endtask

  task automatic test_wrap();
    int  wr = 0, rx = 0, cyc = 0;
    logic wr_hs, rd_hs;
    while ((wr < 10 || rx < 10) && cyc < 300) begin
      s_tvalid = (wr < 10); s_tdata = 8'(wr); s_tlast = (wr == 9);
      m_tready = 1'($urandom_range(0, 1));
      #1;
      wr_hs = s_tvalid && s_tready;
      rd_hs = m_tvalid && m_tready;
      if (rd_hs) begin
        tests++; if (m_tdata !== 8'(rx)) begin fails++; $display("FAIL wrap_order_%0d got %h exp %h", rx, m_tdata, 8'(rx)); end
        rx++;
      end
      tick();
      if (wr_hs) wr++;
      cyc++;
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    tests++; if (rx !== 10 || count !== 3'd0) begin
      fails++; $display("FAIL wrap_complete got rx=%0d cnt=%0d exp 10/0", rx, count); end
  endtask

  task automatic test_reset_mid();
    s_tvalid = 1'b1; s_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin s_tdata = 8'(8'hC0 + i); tick(); end
    s_tvalid = 1'b0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL mid_pre got %0d exp 3", count); end
    rst = 1'b1;
    #1;
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL mid_tready_during got %b exp 0", s_tready); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || m_tvalid !== 1'b0 || m_tdata !== 8'h00 || s_tready !== 1'b1) begin
      fails++; $display("FAIL mid_after got cnt=%0d v=%b d=%h rdy=%b exp 0/0/00/1", count, m_tvalid, m_tdata, s_tready); end
    s_tvalid = 1'b1; s_tdata = 8'h77;
    tick();
    s_tvalid = 1'b0;
    tests++; if (m_tdata !== 8'h77 || count !== 3'd1) begin
      fails++; $display("FAIL mid_fresh got d=%h cnt=%0d exp 77/1", m_tdata, count); end
    m_tready = 1'b1; tick(); m_tready = 1'b0;
  endtask

`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
  task automatic test_pkt_cnt();
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 8'(8'hD0 + i); s_tlast = (i == 2) || (i == 3);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tests++; if (pkt_cnt !== 3'd2) begin fails++; $display("FAIL pkt_after_write got %0d exp 2", pkt_cnt); end
    m_tready = 1'b1;
    tick(); tick(); tick();
    m_tready = 1'b0;
    tests++; if (pkt_cnt !== 3'd1) begin fails++; $display("FAIL pkt_after_read got %0d exp 1", pkt_cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (pkt_cnt !== 3'd0) begin fails++; $display("FAIL pkt_reset got %0d exp 0", pkt_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef AXIS_SYNC_FIFO_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
